bcd_seq_converter: RTL and testbench
====================================

# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces combinational conversion on display and debug paths where the unrolled adder chain is too deep for the core clock. It adds a start/busy/done handshake, an optional two's-complement input mode, and overflow detection when the configured digit count is too small for the input.

## Interface
- WIDTH, 13, binary input width (≥2)
- DIGITS, 4, number of BCD output digits (≥1); may be smaller than needed for 2^WIDTH−1, in which case overflow reporting applies
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only when not busy
- bin  input  WIDTH  binary operand, captured on accepted start
- signed_en  input  1  treat bin as two's complement, captured on accepted start
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: result registers updated this cycle
- bcd  output  4*DIGITS  result, digit k at bits [4k+3:4k] (digit 0 = ones)
- neg  output  1  result is negative (signed_en=1 and bin MSB=1)
- ovf  output  1  magnitude did not fit in DIGITS digits

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1, capture operand, go to SHIFT, clear working digit register and bit counter.
  - Operand capture: if signed_en=1 and bin[WIDTH-1]=1, magnitude = (~bin)+1 as WIDTH-bit unsigned (−2^(WIDTH−1) → 2^(WIDTH−1), exact); neg_next=1. Otherwise magnitude = bin, neg_next=0.
- SHIFT: each cycle, in this order:
  - for every working digit ≥5, add 3 (4-bit, no carry out);
  - shift {digits, magnitude} left by one; magnitude MSB enters digit 0 bit 0;
  - bit shifted out of the top digit bit 3 is OR'd into a sticky ovf_next;
  - increment counter; after exactly WIDTH shifts go to DONE.
- DONE (one cycle): load bcd ← working digits, neg ← neg_next, ovf ← ovf_next; done=1. If start=1 in this cycle it is accepted (operand captured, go to SHIFT); else go to IDLE.
- On overflow, bcd holds the low DIGITS digits of the true result (value mod 10^DIGITS); ovf=1.
- A magnitude of 0 yields bcd=0 with neg reflecting input sign (neg=0, since 0 has MSB=0).
- start while in SHIFT is ignored; bin and signed_en are not sampled.
- bcd, neg, ovf hold their values between done pulses; they change only in DONE.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, counter=0, working registers=0. Reset mid-conversion aborts with no done pulse.
- Start accepted at edge T0 → busy=1 from T0 through the edge that enters DONE; shift occurs on edges T1..TWIDTH; done=1 and new outputs visible in the cycle after edge TWIDTH+1... precisely: state=DONE in cycle WIDTH+1 after acceptance, done=1 that cycle.
- Latency start-accepted → done = WIDTH+1 cycles (14 for defaults).
- busy = (state==SHIFT); busy=0 in IDLE and DONE, so busy can drive start-gating directly.
- Back-to-back throughput: one result per WIDTH+1 cycles when start held high.
- Counter width: clog2(WIDTH+1).

## Test plan
- Defaults, signed_en=0, bin=4095 → after 14 cycles done pulse, bcd=16'h4095, neg=0, ovf=0; bin=0 → bcd=16'h0000.
- Defaults, bin=8191 (max) → bcd=16'h8191, ovf=0; bin=13'h1FFF with signed_en=1 → bcd=16'h0001, neg=1.
- Defaults, signed_en=1, bin=13'h1000 → bcd=16'h4096, neg=1, ovf=0; bin=13'h0FFF → bcd=16'h4095, neg=0.
- WIDTH=13, DIGITS=3, bin=1234 → bcd=12'h234, ovf=1; bin=999 → bcd=12'h999, ovf=0.
- start held high continuously with bin changing: exactly one done per 14 cycles; operand changes during SHIFT do not affect result; pulse on start mid-SHIFT ignored.
- Assert rst at cycle 6 of a conversion → all outputs 0 immediately, no done pulse; next start after release converts correctly.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// Bit-serial binary-to-BCD converter (double dabble), one operand bit per clock.
// Optional two's-complement input and sticky overflow when DIGITS is too small.
module bcd_seq_converter #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  signed_en,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    dig_q, dig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negn_q, negn_d;
  logic             ovfn_q, ovfn_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    adj;
  logic [BW:0]      shl;
  logic             is_neg;
  logic [WIDTH-1:0] cap_mag;

  always_comb begin
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
    end
    // shl[BW] is the bit leaving the top digit
    shl = {adj, mag_q[WIDTH-1]};
  end

  // -2^(WIDTH-1) negates to 2^(WIDTH-1), still exact as unsigned
  assign is_neg  = signed_en & bin[WIDTH-1];
  assign cap_mag = is_neg ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    negn_d  = negn_q;
    ovfn_d  = ovfn_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      SHIFT: begin
        dig_d  = shl[BW-1:0];
        mag_d  = {mag_q[WIDTH-2:0], 1'b0};
        ovfn_d = ovfn_q | shl[BW];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = shl[BW-1:0];
          neg_d   = negn_q;
          ovf_d   = ovfn_q | shl[BW];
        end
      end
      default: begin
        if (start) begin
          state_d = SHIFT;
          mag_d   = cap_mag;
          dig_d   = '0;
          cnt_d   = '0;
          negn_d  = is_neg;
          ovfn_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      negn_q  <= 1'b0;
      ovfn_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      negn_q  <= negn_d;
      ovfn_q  <= ovfn_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Random + directed bench for bcd_seq_converter with 4- and 3-digit instances
// checked every cycle against an arithmetic decimal model.
module tb_bcd_seq_converter;

  localparam int W = 13;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic         signed_en = 0;
  logic [W-1:0] bin = '0;

  logic        busy4, done4, neg4, ovf4;
  logic        busy3, done3, neg3, ovf3;
  logic [15:0] bcd4;
  logic [11:0] bcd3;

  int checks = 0;
  int passed = 0;

  bcd_seq_converter #(.WIDTH(W), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .signed_en(signed_en), .busy(busy4), .done(done4),
    .bcd(bcd4), .neg(neg4), .ovf(ovf4)
  );

  bcd_seq_converter #(.WIDTH(W), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .signed_en(signed_en), .busy(busy3), .done(done3),
    .bcd(bcd3), .neg(neg3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic int unsigned magof(input logic [W-1:0] b,
                                        input logic s);
    if (s && b[W-1]) return (1 << W) - int'(b);
    return int'(b);
  endfunction

  function automatic logic [15:0] dec(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: p=0 idle, 1..W converting, W+1 result cycle.
  int          p = 0;
  logic [15:0] pb4 = '0, pb3 = '0, eb4 = '0, eb3 = '0;
  logic        pn = 0, po4 = 0, po3 = 0;
  logic        en = 0, eo4 = 0, eo3 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= 0;
      eb4 <= '0;
      eb3 <= '0;
      en  <= 0;
      eo4 <= 0;
      eo3 <= 0;
    end else if (p == 0 || p == W + 1) begin
      if (start) begin
        p   <= 1;
        pb4 <= dec(magof(bin, signed_en) % 10000);
        pb3 <= dec(magof(bin, signed_en) % 1000);
        po4 <= magof(bin, signed_en) >= 10000;
        po3 <= magof(bin, signed_en) >= 1000;
        pn  <= signed_en & bin[W-1];
      end else begin
        p <= 0;
      end
    end else begin
      p <= p + 1;
      if (p == W) begin
        eb4 <= pb4;
        eb3 <= pb3;
        en  <= pn;
        eo4 <= po4;
        eo3 <= po3;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy4", busy4, (p >= 1 && p <= W));
    chk("done4", done4, (p == W + 1));
    chk("bcd4", bcd4, eb4);
    chk("neg4", neg4, en);
    chk("ovf4", ovf4, eo4);
    chk("busy3", busy3, (p >= 1 && p <= W));
    chk("done3", done3, (p == W + 1));
    chk("bcd3", bcd3, eb3);
    chk("neg3", neg3, en);
    chk("ovf3", ovf3, eo3);
  end

  task automatic run(input logic [W-1:0] v, input logic s,
                     input logic [15:0] x4, input logic [15:0] x3,
                     input logic xn, input logic xo4, input logic xo3,
                     input bit glitch);
    bit seen;
    seen = 0;
    @(negedge clk);
    start = 1;
    bin = v;
    signed_en = s;
    @(negedge clk);
    start = 0;
    bin = W'($urandom);
    signed_en = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1;
        break;
      end
      start = glitch && (i == 4);
      bin = W'($urandom);
    end
    start = 0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("lit_bcd4", bcd4, x4);
      chk("lit_bcd3", bcd3, x3);
      chk("lit_neg", neg4, xn);
      chk("lit_ovf4", ovf4, xo4);
      chk("lit_ovf3", ovf3, xo3);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bcd4", bcd4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    rst = 0;

    run(13'd4095,  0, 16'h4095, 16'h095, 0, 0, 1, 0);
    run(13'd0,     0, 16'h0000, 16'h000, 0, 0, 0, 0);
    run(13'd8191,  0, 16'h8191, 16'h191, 0, 0, 1, 1);
    run(13'h1FFF,  1, 16'h0001, 16'h001, 1, 0, 0, 0);
    run(13'h1000,  1, 16'h4096, 16'h096, 1, 0, 1, 1);
    run(13'h0FFF,  1, 16'h4095, 16'h095, 0, 0, 1, 0);
    run(13'd1234,  0, 16'h1234, 16'h234, 0, 0, 1, 0);
    run(13'd999,   0, 16'h0999, 16'h999, 0, 0, 0, 1);

    @(negedge clk);
    start = 1;
    bin = 13'd5678;
    signed_en = 0;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_bcd4", bcd4, 0);
    chk("abort_bcd3", bcd3, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    run(13'd1234, 0, 16'h1234, 16'h234, 0, 0, 1, 0);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start = (c % 200 < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bin = W'($urandom);
      signed_en = 1'($urandom);
    end
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
